// File: rtl/emu_trace_tx.sv
// Trace streamer: buffers {time, reset} samples in a FIFO and sends each one as an
// 8N1 UART frame (A5, time bytes LSB first, flags). Optional EMU_TRACE_CHECKSUM_EN appends an XOR byte.
module emu_trace_tx #(
  parameter int TIME_WIDTH   = 32,
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_valid,
  input  logic [TIME_WIDTH-1:0]   sample_time,
  input  logic                    sample_rst,
  input  logic                    clear_ovf,
  output logic                    tx,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  output logic [15:0]             drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = TIME_WIDTH + 1;
  localparam int TB = TIME_WIDTH / 8;
`ifdef EMU_TRACE_CHECKSUM_EN
  localparam int NBYTES = TB + 3;
`else
  localparam int NBYTES = TB + 2;
`endif
  localparam int BW = $clog2(NBYTES);
  localparam int TW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [2:0]        bit_q, bit_d;
  logic [BW-1:0]     byte_q, byte_d;
  logic              tx_q, tx_d;

  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       drop_q, drop_d;

  logic [TIME_WIDTH-1:0] frame_time_q;
  logic [1:0]            frame_flags_q;
`ifdef EMU_TRACE_CHECKSUM_EN
  logic [7:0]            frame_cks_q;
  logic [7:0]            head_cks;
`endif

  logic          pop, push, drop, full, timer_last;
  logic [EW-1:0] head;
  logic [7:0]    cur_byte;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  always_comb begin
    head       = mem_q[rd_ptr_q];
    full       = (count_q == CW'(DEPTH));
    pop        = (state_q == S_IDLE) && (count_q != '0);
    push       = sample_valid && (!full || pop);
    drop       = sample_valid && full && !pop;
    timer_last = (timer_q == TW'(CLKS_PER_BIT - 1));
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clear_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
  end

`ifdef EMU_TRACE_CHECKSUM_EN
  always_comb begin
    head_cks = 8'hA5 ^ {6'b0, ovf_q, head[0]};
    for (int unsigned i = 0; i < TB; i++) head_cks = head_cks ^ head[1 + i*8 +: 8];
  end
`endif

  always_comb begin
    cur_byte = 8'hA5;
    for (int unsigned i = 0; i < TB; i++)
      if (byte_q == BW'(i + 1)) cur_byte = frame_time_q[i*8 +: 8];
    if (byte_q == BW'(TB + 1)) cur_byte = {6'b0, frame_flags_q};
`ifdef EMU_TRACE_CHECKSUM_EN
    if (byte_q == BW'(TB + 2)) cur_byte = frame_cks_q;
`endif
  end

  // tx_d is the level for the next cycle, so tx is a pure flop output.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        tx_d    = 1'b1;
        timer_d = '0;
        bit_d   = '0;
        byte_d  = '0;
        if (pop) begin
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (timer_last) begin
          timer_d = '0;
          state_d = S_DATA;
          tx_d    = cur_byte[0];
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DATA: begin
        if (timer_last) begin
          timer_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_d];
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STOP: begin
        if (timer_last) begin
          timer_d = '0;
          bit_d   = '0;
          if (byte_q == BW'(NBYTES - 1)) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = S_START;
            tx_d    = 1'b0;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {sample_time, sample_rst};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      bit_q         <= '0;
      byte_q        <= '0;
      tx_q          <= 1'b1;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      drop_q        <= '0;
      frame_time_q  <= '0;
      frame_flags_q <= '0;
`ifdef EMU_TRACE_CHECKSUM_EN
      frame_cks_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q      <= rd_ptr_q + 1'b1;
        frame_time_q  <= head[EW-1:1];
        frame_flags_q <= {ovf_q, head[0]};
`ifdef EMU_TRACE_CHECKSUM_EN
        frame_cks_q   <= head_cks;
`endif
      end
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE);
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_emu_trace_tx.sv
// Directed bench for emu_trace_tx: frame vectors from a table plus multi-cycle
// sequences for overflow, same-cycle push/pop, clear priority and mid-frame reset.
module tb_emu_trace_tx;
  localparam int C  = 4;
  localparam int TW = 32;
  localparam int D  = 4;
`ifdef EMU_TRACE_CHECKSUM_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif
  localparam int FRAME_CYC = NB * 10 * C;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sample_valid;
  logic [TW-1:0] sample_time;
  logic          sample_rst;
  logic          clear_ovf;
  logic          tx;
  logic          busy;
  logic [2:0]    fifo_count;
  logic          overflow;
  logic [15:0]   drop_count;

  int vecs  = 0;
  int fails = 0;
  logic tx_hist [0:399];

  typedef struct packed {
    logic [31:0]     t;
    logic            r;
    logic [0:6][7:0] b;
  } vec_t;
  vec_t tbl [0:3];

  always #5 clk = ~clk;

  emu_trace_tx #(.TIME_WIDTH(TW), .DEPTH(D), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_time(sample_time),
    .sample_rst(sample_rst), .clear_ovf(clear_ovf), .tx(tx), .busy(busy),
    .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [0:6][7:0] mk(input logic [31:0] t, input logic [7:0] f);
    logic [0:6][7:0] e;
    e[0] = 8'hA5;
    e[1] = t[7:0];
    e[2] = t[15:8];
    e[3] = t[23:16];
    e[4] = t[31:24];
    e[5] = f;
    e[6] = e[0] ^ e[1] ^ e[2] ^ e[3] ^ e[4] ^ e[5];
    return e;
  endfunction

  task automatic push(input logic [31:0] t, input logic r);
    sample_time  = t;
    sample_rst   = r;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Called on a negedge; if busy is already high that cycle is frame cycle 0.
  task automatic recv_frame(input logic [0:6][7:0] exp, input string nm);
    int unsigned guard, n, base;
    logic [7:0] b;
    logic framing;
    guard = 0;
    while (!busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!busy) begin
      chk({nm, "_start_timeout"}, 32'd0, 32'd1);
      return;
    end
    n = 0;
    while (busy && n < 400) begin
      tx_hist[n] = tx;
      n++;
      @(negedge clk);
    end
    chk({nm, "_busy_cycles"}, n, FRAME_CYC);
    for (int k = 0; k < NB; k++) begin
      base    = k * 10 * C;
      framing = (tx_hist[base + 1] === 1'b0) && (tx_hist[base + 38] === 1'b1);
      for (int j = 0; j < 8; j++) b[j] = tx_hist[base + 4 + 4*j + 2];
      chk($sformatf("%s_byte%0d", nm, k), {framing, 23'd0, b}, {1'b1, 23'd0, exp[k]});
    end
    chk({nm, "_idle_tx"}, tx, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int busy_seen;
    tbl[0] = '{t: 32'h12345678, r: 1'b1, b: {8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h01, 8'hAC}};
    tbl[1] = '{t: 32'h00000000, r: 1'b0, b: {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}};
    tbl[2] = '{t: 32'hFFFFFFFF, r: 1'b1, b: {8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'hA4}};
    tbl[3] = '{t: 32'hDEADBEEF, r: 1'b0, b: {8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h87}};

    rst_n = 1'b0; sample_valid = 1'b0; sample_time = '0; sample_rst = 1'b0; clear_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_drop", drop_count, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset held while requests toggle: nothing captured.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_valid = ~sample_valid;
      sample_time  = 32'hCAFE0000 + i;
      @(negedge clk);
      chk($sformatf("rsthold_tx%0d", i), tx, 1'b1);
      chk($sformatf("rsthold_cnt%0d", i), fifo_count, 3'd0);
      chk($sformatf("rsthold_ovf%0d", i), overflow, 1'b0);
    end
    sample_valid = 1'b0;
    rst_n = 1'b1;
    busy_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    chk("rsthold_no_frame", busy_seen, 0);
    chk("rsthold_cnt_after", fifo_count, 3'd0);

    for (int i = 0; i < 4; i++) begin
      push(tbl[i].t, tbl[i].r);
      recv_frame(tbl[i].b, $sformatf("vec%0d", i));
    end

    // Seven back-to-back pushes: one popped, four buffered, two dropped.
    fork
      recv_frame(mk(32'h100, 8'h00), "ovf_f0");
      begin
        for (int i = 0; i < 7; i++) begin
          sample_valid = 1'b1;
          sample_time  = 32'h100 + i;
          sample_rst   = 1'b0;
          @(negedge clk);
        end
        sample_valid = 1'b0;
        chk("ovf_count", fifo_count, 3'd4);
        chk("ovf_drop", drop_count, 16'd2);
        chk("ovf_flag", overflow, 1'b1);
      end
    join

    // Idle cycle between frames: push on full FIFO during the pop is accepted.
    sample_valid = 1'b1; sample_time = 32'h200; sample_rst = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("pushpop_gap_busy", busy, 1'b1);
    chk("pushpop_count", fifo_count, 3'd4);
    chk("pushpop_drop", drop_count, 16'd2);

    fork
      recv_frame(mk(32'h101, 8'h02), "ovf_f1");
      begin
        sample_valid = 1'b1; clear_ovf = 1'b1; sample_time = 32'h300;
        @(negedge clk);
        sample_valid = 1'b0; clear_ovf = 1'b0;
        chk("clr_ovf", overflow, 1'b0);
        chk("clr_drop", drop_count, 16'd0);
        chk("clr_count", fifo_count, 3'd4);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("redrop_drop", drop_count, 16'd1);
        chk("redrop_ovf", overflow, 1'b1);
      end
    join
    recv_frame(mk(32'h102, 8'h02), "ovf_f2");
    recv_frame(mk(32'h103, 8'h02), "ovf_f3");
    recv_frame(mk(32'h104, 8'h02), "ovf_f4");
    recv_frame(mk(32'h200, 8'h03), "ovf_f5");
    chk("drain_count", fifo_count, 3'd0);

    // Reset during a data bit of byte 2 aborts the frame and empties the FIFO.
    push(32'h0, 1'b0);
    push(32'h1, 1'b0);
    push(32'h2, 1'b0);
    repeat (89) @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    chk("mid_tx", tx, 1'b0);
    chk("mid_count", fifo_count, 3'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_count", fifo_count, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    chk("midrst_no_frame", busy_seen, 0);
    chk("midrst_count_after", fifo_count, 3'd0);
    chk("midrst_tx_after", tx, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/emu_trace_tx.md
# emu_trace_tx

Transmit-side trace streamer for the emulation top level. It samples emulation time and the emulation reset state on request and buffers the samples in a small FIFO. It then serializes each sample as a framed 8N1 UART byte stream on a single pin toward the host. It is the FPGA→host counterpart to the host→FPGA reset control path, and sits in the `emu_clk` domain next to the testbench instance.

## Interface
Parameters:
- `TIME_WIDTH`, 32: width of the emulation time sample. Multiple of 8, range 8..64.
- `DEPTH`, 8: FIFO depth in samples. Power of 2, ≥2.
- `CLKS_PER_BIT`, 868: `clk` cycles per UART bit (100 MHz / 115200). Must be ≥2.

Ports:
- `clk`, in, 1: emulation clock; all logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `sample_valid`, in, 1: capture request, one sample per high cycle.
- `sample_time`, in, `TIME_WIDTH`: emulation time to capture.
- `sample_rst`, in, 1: emulation reset state to capture.
- `clear_ovf`, in, 1: synchronous clear of `overflow` and `drop_count`.
- `tx`, out, 1: UART serial output; idles high.
- `busy`, out, 1: high while a frame is being shifted out.
- `fifo_count`, out, `$clog2(DEPTH)+1`: number of samples buffered.
- `overflow`, out, 1: sticky; set when any sample is dropped.
- `drop_count`, out, 16: number of dropped samples, saturating at 0xFFFF.

## Operation
- Reset (async assert, sync release):
  - `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0, `drop_count`=0.
  - FSM enters IDLE; FIFO pointers are 0.
- Push: the sample {`sample_time`, `sample_rst`} is written when `sample_valid`=1 and the FIFO is not full.
  - Full means `fifo_count`==`DEPTH` at the start of the cycle, unless a pop occurs in the same cycle. In that case the push is accepted and the count is unchanged.
- Drop: a sample offered while the FIFO is full with no same-cycle pop is discarded.
  - `overflow`←1; `drop_count` increments, saturating at 0xFFFF.
  - If `clear_ovf` is high in the same cycle as a drop, the clear wins: both are 0 next cycle.
- Frame format, bytes sent in order:
  - sync 0xA5;
  - `TIME_WIDTH/8` time bytes, LSB first;
  - flags byte: bit0=`sample_rst`, bit1=`overflow` at pop time, bits7:2=0.
- Each byte is sent as: start bit (0), 8 data bits LSB first, stop bit (1).
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the frame register and go to START; otherwise stay.
  - START: drive 0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: 8 bits, each held `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: drive 1 for `CLKS_PER_BIT` cycles. If more bytes remain in the frame, go to START with the next byte; otherwise go to IDLE.
- `busy` is high in START, DATA and STOP, and low in IDLE.
- Bit timer: a counter runs 0..`CLKS_PER_BIT`-1 and wraps. The bit index is 0..7; the byte index is 0..N-1.
- Reset asserted mid-frame aborts the frame immediately: `tx`=1 and all buffered samples are lost.

## Timing
- Push latency: a sample accepted at edge k is reflected in `fifo_count` after edge k.
- Pop: in IDLE with `fifo_count`>0, the pop occurs at edge n and `tx` falls after edge n (the output is registered).
- Byte duration: exactly 10×`CLKS_PER_BIT` cycles.
- Bytes within a frame are back-to-back with no idle gap.
- Frames are separated by exactly 1 idle cycle, spent in IDLE.
- Frame length: (2 + `TIME_WIDTH/8` [+1 with checksum]) × 10 × `CLKS_PER_BIT` cycles, plus 1 for the IDLE cycle.
- `tx` is glitch-free and comes directly from a flop.

## Configuration
- `EMU_TRACE_CHECKSUM_EN` defined:
  - One extra byte is appended after the flags byte.
  - Its value is the XOR of all preceding bytes in the frame, sync included.
- Not defined: frames end at the flags byte, and no checksum logic is instantiated.

## Test plan
Common settings: `CLKS_PER_BIT`=4, `TIME_WIDTH`=32, `DEPTH`=4.
- Single sample: time=0x12345678, rst=1.
  - Without checksum: bytes A5 78 56 34 12 01; `busy` high for 240 cycles.
  - With `EMU_TRACE_CHECKSUM_EN`: extra byte 0xAC; 280 cycles.
- Reset values: hold `rst_n`=0 for 3 cycles while toggling `sample_valid`. Outputs stay `tx`=1, `fifo_count`=0 and `overflow`=0; no frame follows the release.
- Overflow: push 7 samples on consecutive cycles.
  - The first is popped at once and 4 are buffered, so 2 are dropped: `drop_count`=2 and `overflow`=1.
  - The second frame's flags byte is 0x02 (rst=0).
- Push on a full FIFO in the cycle of a pop: the sample is accepted, `fifo_count` stays 4 and `drop_count` is unchanged.
- `clear_ovf` in the same cycle as a drop: next cycle `overflow`=0 and `drop_count`=0.
- Mid-frame reset: assert `rst_n` during the DATA state of byte 2. `tx`=1 immediately (asynchronously), `busy`=0, and the FIFO is empty after release.
